// File: rtl/alu_issue_queue.sv
// alu_issue_queue: in-order ALU issue queue with a busy-bit register scoreboard.
// Optional macro ALU_IQ_WB_BYPASS_EN lets a same-cycle writeback wake the head op.
package alu_iq_pkg;
  typedef struct packed {
    logic [7:0]  opc;
    logic [15:0] imm;
    logic [7:0]  tag;
  } micro_op_t;
endpackage

module alu_issue_queue
  import alu_iq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RID_W = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  micro_op_t                in_mop,
  input  logic [RID_W-1:0]         in_src0_id,
  input  logic [RID_W-1:0]         in_src1_id,
  input  logic [RID_W-1:0]         in_dst_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output micro_op_t                out_mop,
  input  logic                     wb_valid,
  input  logic [RID_W-1:0]         wb_id,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int NR = 2**RID_W;

  micro_op_t        r_mop  [DEPTH];
  logic [RID_W-1:0] r_src0 [DEPTH];
  logic [RID_W-1:0] r_src1 [DEPTH];
  logic [RID_W-1:0] r_dst  [DEPTH];
  logic [PW-1:0]    r_head, r_tail;
  logic [PW:0]      r_count;
  logic [NR-1:0]    r_busy;
  logic [NR-1:0]    w_wake, w_busy, w_set, w_clr;
  logic [RID_W-1:0] w_s0, w_s1, w_d;
  logic             w_push, w_pop;

  assign w_s0 = r_src0[r_head];
  assign w_s1 = r_src1[r_head];
  assign w_d  = r_dst[r_head];

`ifdef ALU_IQ_WB_BYPASS_EN
  assign w_wake = wb_valid ? NR'(1) << wb_id : '0;
`else
  assign w_wake = '0;
`endif

  // register 0 means "no register" and never blocks issue
  assign w_busy    = r_busy & ~w_wake & ~NR'(1);
  assign in_ready  = (r_count < (PW+1)'(DEPTH)) && !flush;
  assign out_valid = (r_count != '0) && !flush && !w_busy[w_s0] && !w_busy[w_s1] && !w_busy[w_d];
  assign out_mop   = r_mop[r_head];
  assign count     = r_count;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_set     = w_pop ? (NR'(1) << w_d) & ~NR'(1) : '0;
  assign w_clr     = wb_valid ? NR'(1) << wb_id : '0;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
    end else begin
      // set applied after clear so an issuing writer wins over a stale writeback
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + PW'(1);
        if (w_pop) r_head <= r_head + PW'(1);
        r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      end
    end

  always_ff @(posedge clk)
    if (w_push) begin
      r_mop[r_tail]  <= in_mop;
      r_src0[r_tail] <= in_src0_id;
      r_src1[r_tail] <= in_src1_id;
      r_dst[r_tail]  <= in_dst_id;
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// tb_alu_issue_queue: directed scoreboard bench for alu_issue_queue.
// Expected wakeup timing follows ALU_IQ_WB_BYPASS_EN when defined.
module tb_alu_issue_queue;
  import alu_iq_pkg::*;

`ifdef ALU_IQ_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_ready, out_valid, out_ready, wb_valid, flush;
  micro_op_t  in_mop, out_mop;
  logic [4:0] in_src0_id, in_src1_id, in_dst_id, wb_id;
  logic [2:0] count;

  micro_op_t sb [$];
  int n_chk = 0;
  int n_fail = 0;

  alu_issue_queue #(.DEPTH(4), .RID_W(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mop(in_mop),
    .in_src0_id(in_src0_id), .in_src1_id(in_src1_id), .in_dst_id(in_dst_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_mop(out_mop),
    .wb_valid(wb_valid), .wb_id(wb_id), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  function automatic micro_op_t mk(input int t);
    mk = '{opc: 8'(t) ^ 8'h5a, imm: {8'(t), 8'hc3}, tag: 8'(t)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit v, input int t, input int s0, input int s1, input int d);
    in_valid   = v;
    in_mop     = mk(t);
    in_src0_id = 5'(s0);
    in_src1_id = 5'(s1);
    in_dst_id  = 5'(d);
  endtask

  task automatic tick();
    #1;
    if (flush) sb.delete();
    else begin
      if (in_valid && in_ready) sb.push_back(in_mop);
      if (out_valid && out_ready) begin
        chk("sb_has_entry", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) chk("issue_mop", out_mop, sb.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic wake(input int id);
    wb_valid = 1'b1;
    wb_id    = 5'(id);
    #1 chk("wake_same_cycle", 32'(out_valid), 32'(BYP));
    tick();
    wb_valid = 1'b0;
    wb_id    = 5'd0;
    #1 chk("wake_next_cycle", 32'(out_valid), 32'(!BYP));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b0;
    wb_valid = 1'b0;
    wb_id = 5'd0;
    flush = 1'b0;
    drv(0, 0, 0, 0, 0);
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_count", 32'(count), 0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // fill with four independent ops, then drain in order
    for (int i = 0; i < 4; i++) begin
      drv(1, i + 1, 2 * i + 1, 0, 2 * i + 2);
      #1 chk("fill_count", 32'(count), 32'(i));
      chk("fill_in_ready", 32'(in_ready), 1);
      tick();
    end
    drv(0, 0, 0, 0, 0);
    #1 chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_out_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("drain_out_valid", 32'(out_valid), 1);
      chk("drain_count", 32'(count), 32'(4 - i));
      tick();
    end
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1;
      wb_id = 5'(2 * i);
      tick();
    end
    wb_valid = 1'b0;
    #1 chk("drained_count", 32'(count), 0);

    // RAW stall on reg 5
    drv(1, 16, 0, 0, 5);
    tick();
    drv(1, 17, 5, 0, 10);
    #1 chk("raw_a_valid", 32'(out_valid), 1);
    tick();
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("raw_b_stall", 32'(out_valid), 0);
      chk("raw_b_count", 32'(count), 1);
      tick();
    end
    wake(5);
    #1 chk("raw_done_count", 32'(count), 0);

    // full queue refuses input even when popping
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1, 32 + i, 0, 0, 0);
      tick();
    end
    drv(1, 40, 0, 0, 0);
    out_ready = 1'b1;
    wb_valid = 1'b1;
    wb_id = 5'd10;
    #1 chk("fullpop_count", 32'(count), 4);
    chk("fullpop_in_ready", 32'(in_ready), 0);
    chk("fullpop_out_valid", 32'(out_valid), 1);
    tick();
    wb_valid = 1'b0;
    drv(0, 0, 0, 0, 0);
    #1 chk("fullpop_after", 32'(count), 3);
    tick();
    tick();
    tick();
    #1 chk("fullpop_drained", 32'(count), 0);

    // set/clear collision on reg 9
    drv(1, 48, 0, 0, 9);
    tick();
    drv(0, 0, 0, 0, 0);
    wb_valid = 1'b1;
    wb_id = 5'd9;
    #1 chk("coll_pop_valid", 32'(out_valid), 1);
    tick();
    wb_valid = 1'b0;
    drv(1, 49, 0, 9, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    #1 chk("coll_stall", 32'(out_valid), 0);
    chk("coll_count", 32'(count), 1);
    tick();
    #1 chk("coll_stall2", 32'(out_valid), 0);
    tick();
    wake(9);
    #1 chk("coll_done_count", 32'(count), 0);

    // flush with head blocked on reg 2; busy survives the flush
    drv(1, 56, 0, 0, 2);
    tick();
    drv(1, 57, 2, 0, 0);
    tick();
    drv(1, 58, 0, 0, 0);
    #1 chk("flush_head_blocked", 32'(out_valid), 0);
    tick();
    drv(1, 59, 0, 0, 0);
    tick();
    drv(1, 60, 0, 0, 0);
    flush = 1'b1;
    #1 chk("flush_pre_count", 32'(count), 3);
    chk("flush_in_ready", 32'(in_ready), 0);
    chk("flush_out_valid", 32'(out_valid), 0);
    tick();
    flush = 1'b0;
    drv(0, 0, 0, 0, 0);
    #1 chk("flush_count", 32'(count), 0);
    drv(1, 61, 0, 2, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    #1 chk("flush_busy_kept", 32'(out_valid), 0);
    tick();
    wake(2);
    #1 chk("flush_done_count", 32'(count), 0);

    // asynchronous reset mid-operation
    drv(1, 64, 0, 0, 2);
    tick();
    drv(0, 0, 0, 0, 0);
    tick();
    out_ready = 1'b0;
    drv(1, 65, 0, 0, 0);
    tick();
    drv(1, 66, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    #1 chk("mid_count", 32'(count), 2);
    chk("mid_out_valid", 32'(out_valid), 1);
    #2 reset_n = 1'b0;
    #1 chk("arst_count", 32'(count), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    drv(1, 67, 2, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0);
    #1 chk("post_rst_no_stall", 32'(out_valid), 1);
    tick();
    #1 chk("post_rst_count", 32'(count), 0);
    chk("sb_empty_end", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
